// File: rtl/memory_stage_pkg.sv
// Shared pipeline definitions: opcode constants, memory-stage FSM states and
// the writeback payload carried from the memory stage to the register file.
package memory_stage_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 4;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_ADD   = 5'b00000;
  localparam opcode_t OP_SUB   = 5'b00001;
  localparam opcode_t OP_LOAD  = 5'b01101;
  localparam opcode_t OP_LOADI = 5'b01110;
  localparam opcode_t OP_STORE = 5'b01111;
  localparam opcode_t OP_MOV   = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_payload_t;

  function automatic logic is_mem_op(input opcode_t op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Encodings above MOV are unassigned and retire as no-ops.
  function automatic logic is_nop_op(input opcode_t op);
    return op > OP_MOV;
  endfunction

endpackage

// File: rtl/memory_stage_wait_timer.sv
// Saturating wait counter for an outstanding data-memory access; expired is
// high once ACK_TIMEOUT cycles have been spent waiting (count == ACK_TIMEOUT-1).
module mem_wait_timer #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = (count_q == CNT_LAST);

  // Holds at the terminal value instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: ALU results bypass to writeback in one cycle, LOAD and
// STORE run a request/ack handshake with a bounded wait and a sticky error.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [OP_W-1:0]   ex_control,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_dest,
  input  logic              ex_we,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  mem_state_e        state_q, state_d;
  logic              ex_ready_q, ex_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic              wb_valid_q, wb_valid_d;
  wb_payload_t       wb_q, wb_d;
  logic              mem_err_q, mem_err_d;
  logic              timer_clear, timer_en, timer_expired;

  mem_wait_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dest_d      = dest_q;
    wb_valid_d  = 1'b0;
    wb_d        = wb_q;
    mem_err_d   = mem_err_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (is_mem_op(ex_control)) begin
            state_d     = ST_ACCESS;
            mem_req_d   = 1'b1;
            mem_wr_d    = (ex_control == OP_STORE);
            mem_addr_d  = ex_result;
            mem_wdata_d = ex_store_data;
            dest_d      = ex_dest;
            timer_clear = 1'b1;
          end else begin
            wb_valid_d = 1'b1;
            wb_d.dest  = ex_dest;
            if (is_nop_op(ex_control)) begin
              wb_d.we   = 1'b0;
              wb_d.data = '0;
            end else begin
              wb_d.we   = ex_we;
              wb_d.data = ex_result;
            end
          end
        end
      end

      ST_ACCESS: begin
        // An ack wins over a timeout landing on the same edge.
        if (mem_ack || timer_expired) begin
          state_d    = ST_DONE;
          mem_req_d  = 1'b0;
          mem_wr_d   = 1'b0;
          wb_valid_d = 1'b1;
          wb_d.dest  = dest_q;
          wb_d.we    = 1'b0;
          wb_d.data  = '0;
          if (!mem_ack) begin
            mem_err_d = 1'b1;
          end else if (!mem_wr_q) begin
            wb_d.we   = 1'b1;
            wb_d.data = mem_rdata;
          end
        end else begin
          timer_en = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ex_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ex_ready_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dest_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_q        <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ex_ready_q  <= ex_ready_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dest_q      <= dest_d;
      wb_valid_q  <= wb_valid_d;
      wb_q        <= wb_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign ex_ready  = ex_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_q.we;
  assign wb_dest   = wb_q.dest;
  assign wb_data   = wb_q.data;
  assign mem_err   = mem_err_q;

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, is the maximum number of cycles an access waits for mem_ack.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ex_valid  input  1  execute-stage result valid this cycle.
REQ-005 ex_ready  output  1  stage can accept; high only in IDLE.
REQ-006 ex_control  input  5  opcode from execute (ADD=00000 … MOV=10000).
REQ-007 ex_result  input  16  ALU result; memory address for LOAD/STORE.
REQ-008 ex_store_data  input  16  data to write for STORE.
REQ-009 ex_dest  input  4  destination register index.
REQ-010 ex_we  input  1  execute-stage register-write request.
REQ-011 mem_req, mem_wr  output  1 each  data-memory request; write when mem_wr=1.
REQ-012 mem_addr, mem_wdata  output  16 each  request address and write data.
REQ-013 mem_ack  input  1  memory completion; mem_rdata valid in the same cycle.
REQ-014 mem_rdata  input  16  load data.
REQ-015 wb_valid, wb_we  output  1 each  writeback valid pulse and register-write enable.
REQ-016 wb_dest  output  4  writeback register index.
REQ-017 wb_data  output  16  writeback data.
REQ-018 mem_err  output  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-020 A transfer SHALL occur on a posedge where ex_valid=1 and ex_ready=1.
REQ-021 Non-memory opcodes, including LOADI, SHALL bypass memory.
- Register to wb_* at the accept edge.
- wb_valid=1 for exactly one cycle.
- wb_we=ex_we, wb_data=ex_result.
- State stays IDLE, so back-to-back accepts run at one per cycle.
REQ-022 LOAD (01101) or STORE (01111) accepted SHALL latch address, data, dest and opcode, then enter ACCESS.
REQ-023 In ACCESS the stage SHALL hold mem_req=1 and stable mem_addr, mem_wdata and mem_wr (1 for STORE) until the edge where mem_ack=1 or the timeout expires.
REQ-024 On mem_ack in ACCESS the stage SHALL enter DONE.
- LOAD: capture mem_rdata into wb_data, wb_we=1.
- STORE: wb_we=0, wb_data=0.
- mem_req deasserts the cycle after the ack.
REQ-025 DONE SHALL assert wb_valid for one cycle, then return to IDLE; ex_ready=0 in ACCESS and DONE.
REQ-026 The wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
REQ-027 When the counter reaches ACK_TIMEOUT-1 with no ack, the stage SHALL enter DONE with wb_we=0 and set mem_err=1 until reset.
REQ-028 An ack and a timeout on the same edge SHALL be treated as an ack; mem_err stays unchanged.
REQ-029 mem_ack outside ACCESS SHALL be ignored.
REQ-030 Opcodes above MOV (10001–11111) SHALL be treated as NOP: wb_valid=1, wb_we=0.
REQ-031 The wait counter SHALL be sized ceil(log2(ACK_TIMEOUT))+1 bits and SHALL NOT wrap.

Reset
REQ-032 On rst=1 at posedge the stage SHALL:
- go to IDLE;
- drive mem_req, mem_wr, wb_valid, wb_we and mem_err to 0;
- drive mem_addr, mem_wdata, wb_data and wb_dest to 0;
- clear the wait counter.
REQ-033 Reset during ACCESS SHALL abandon the access with no wb_valid; mem_req is low from the cycle after the reset edge.
REQ-034 rst SHALL take priority over ex_valid and mem_ack on the same edge.

Structure
REQ-035 The 5-bit opcode constants and the FSM state encodings SHALL live in a shared pipeline package, also used by execute.
REQ-036 The wait counter SHALL be a sub-module mem_wait_timer with inputs clear and enable and output expired.

Verification
REQ-037 ADD path: accept ex_control=00000, ex_result=0x1234, ex_dest=3, ex_we=1 → next cycle wb_valid=1, wb_dest=3, wb_data=0x1234, wb_we=1, mem_req never high.
REQ-038 LOAD with 3-cycle ack latency: ex_result=0x0040, mem_rdata=0xBEEF on the ack cycle → mem_req high 3 cycles at addr 0x0040, then wb_data=0xBEEF, wb_we=1; ex_ready=0 throughout.
REQ-039 STORE with same-cycle ack: ex_result=0x0010, ex_store_data=0x00AA → one mem_req cycle with mem_wr=1 and mem_wdata=0x00AA, then wb_valid=1 with wb_we=0.
REQ-040 Timeout with ACK_TIMEOUT=4 and no ack → mem_req high 4 cycles, then wb_valid=1, wb_we=0, mem_err=1 held through later ops.
REQ-041 Reset in cycle 2 of a LOAD → mem_req low the next cycle, no wb_valid, ex_ready=1, mem_err=0.
REQ-042 Back-to-back SUB, MOV, then opcode 10101 → three consecutive wb_valid cycles with wb_we=1, 1, 0.
